// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder family: default geometry,
// operation encoding and the signed-overflow helper.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Signed overflow of an adder: carry into the sign bit differs from carry out of it.
    function automatic logic signed_ovf(input logic c_msb, input logic c_out);
        return c_msb ^ c_out;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice. Besides the carry out it exposes
// the carry into its MSB so the top slice can report signed overflow.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] carry_s;

    // Ripple the carry bit by bit across the slice.
    always_comb begin
        carry_s    = {(CHUNK+1){1'b0}};
        sum        = {CHUNK{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[CHUNK];
    assign cmsb = carry_s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined two's-complement adder/subtractor, one CHUNK-bit slice per stage.
// Optional signed-overflow output is enabled with `define ADDER_OVERFLOW_EN.
module pipelined_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             en_s;
    op_e              op_s;
    logic [WIDTH-1:0] b_eff_s;

    // A stalled result freezes the whole pipeline, bubbles included.
    assign en_s     = ~(out_valid & ~out_ready);
    assign in_ready = en_s;
    assign op_s     = op_e'(sub);
    assign b_eff_s  = (op_s == OP_SUB) ? ~b : b;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * CHUNK;
            localparam int HI = LO + CHUNK - 1;

            // word carries resolved sum bits below LO and still-unresolved A bits above.
            logic [WIDTH-1:0]  word_in_s;
            logic [WIDTH-1:LO] b_in_s;
            logic              cin_s;
            logic              vin_s;
            logic [CHUNK-1:0]  slice_sum_s;
            logic              cout_s;
            logic              cmsb_s;
            logic [WIDTH-1:0]  word_nxt_s;
            logic [WIDTH-1:0]  word_r;
            logic              carry_r;
            logic              valid_r;

            if (k == 0) begin : g_head
                assign word_in_s = a;
                assign b_in_s    = b_eff_s;
                assign cin_s     = carry_in;
                assign vin_s     = in_valid;
            end else begin : g_link
                assign word_in_s = g_stage[k-1].word_r;
                assign b_in_s    = g_fwd[k-1].b_hi_r;
                assign cin_s     = g_stage[k-1].carry_r;
                assign vin_s     = g_stage[k-1].valid_r;
            end

            adder_chunk #(
                .CHUNK (CHUNK)
            ) u_chunk (
                .a    (word_in_s[HI:LO]),
                .b    (b_in_s[HI:LO]),
                .cin  (cin_s),
                .sum  (slice_sum_s),
                .cout (cout_s),
                .cmsb (cmsb_s)
            );

            // Replace this stage's operand slice with its resolved sum slice.
            always_comb begin
                word_nxt_s        = word_in_s;
                word_nxt_s[HI:LO] = slice_sum_s;
            end

            // Stage register: resolved word, inter-stage carry and beat valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_r  <= {WIDTH{1'b0}};
                    carry_r <= 1'b0;
                    valid_r <= 1'b0;
                end else if (en_s) begin
                    word_r  <= word_nxt_s;
                    carry_r <= cout_s;
                    valid_r <= vin_s;
                end
            end
        end

        for (k = 0; k < STAGES - 1; k++) begin : g_fwd
            logic [WIDTH-1:(k+1)*CHUNK] b_hi_r;

            // Forward the B' slices that later stages still need.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_hi_r <= {(WIDTH-(k+1)*CHUNK){1'b0}};
                end else if (en_s) begin
                    b_hi_r <= g_stage[k].b_in_s[WIDTH-1:(k+1)*CHUNK];
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_r;
    assign sum       = g_stage[STAGES-1].word_r;
    assign carry_out = g_stage[STAGES-1].carry_r;

`ifdef ADDER_OVERFLOW_EN
    logic overflow_r;

    // Overflow is taken from the top slice and registered beside sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (en_s) begin
            overflow_r <= signed_ovf(g_stage[STAGES-1].cmsb_s, g_stage[STAGES-1].cout_s);
        end
    end

    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed self-checking bench for pipelined_adder_n (WIDTH=16, CHUNK=4, latency 4).
module tb_pipelined_adder_n;
    import adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef ADDER_OVERFLOW_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_adder_n #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One beat, then wait out the latency and check the result.
    task automatic single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input op_e op, input logic [15:0] exp_sum,
                          input logic exp_co, input logic exp_ovf);
        a = av; b = bv; carry_in = ci; sub = op; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, carry_out}, {31'd0, exp_co});
`ifdef ADDER_OVERFLOW_EN
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 32'd0, 32'd1);
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst_n = 1'b0; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
        carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, carry_out}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ADDER_OVERFLOW_EN
        check("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        single("ripple", 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
        single("subtract", 16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
        single("ovf_add", 16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
        single("ovf_sub", 16'h8000, 16'h0001, 1'b1, OP_SUB, 16'h7FFF, 1'b1, 1'b1);
        single("cin_add", 16'h1234, 16'h4321, 1'b1, OP_ADD, 16'h5556, 1'b0, 1'b0);

        // Streaming: 8 back-to-back beats a=b=i.
        for (int c = 0; c <= 12; c++) begin
            check($sformatf("stream_valid_c%0d", c), {31'd0, out_valid},
                  (c >= LAT && c < LAT + 8) ? 32'd1 : 32'd0);
            if (c >= LAT && c < LAT + 8)
                check($sformatf("stream_sum_c%0d", c), {16'd0, sum}, 32'(2 * (c - LAT + 1)));
            if (c < 8) begin
                a = 16'(c + 1); b = 16'(c + 1); carry_in = 1'b0; sub = OP_ADD; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Backpressure: fill the pipeline, then stall the output for 3 cycles.
        for (int j = 0; j < 4; j++) begin
            a = 16'(16'h0100 + j); b = 16'h0010; carry_in = 1'b0; sub = OP_ADD; in_valid = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        a = 16'h0104;
        #1;
        check("bp_in_ready_0", {31'd0, in_ready}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready_s%0d", s), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_valid_s%0d", s), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_sum_s%0d", s), {16'd0, sum}, 32'h0110);
        end
        out_ready = 1'b1;
        idx = 0;
        for (int t = 0; t < 12; t++) begin
            if (out_valid) begin
                if (idx < 5)
                    check($sformatf("bp_order_%0d", idx), {16'd0, sum}, 32'(32'h0110 + idx));
                idx++;
            end
            if (t == 1) in_valid = 1'b0;
            @(negedge clk);
        end
        check("bp_count", 32'(idx), 32'd5);

        // Reset with three beats in flight.
        for (int j = 0; j < 3; j++) begin
            a = 16'(16'h0A00 + j); b = 16'h0B00; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_cout", {31'd0, carry_out}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet_%0d", t), {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
